// File: rtl/mem_access_unit_if.sv
// Execute-side, data-bus and writeback signals of mem_access_unit.
// master: the unit's own view; slave: the view of the pipeline/bus around it.
interface mem_access_unit_if;
  // Execute handshake: a transfer happens on a rising edge where ex_valid and ex_ready are both 1.
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_out;
  logic [31:0] rs2_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        reg_write;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misaligned;
  logic        bus_err;

  modport master (
    input  ex_valid, alu_out, rs2_data, mem_read, mem_write, funct3, rd, reg_write,
    input  bus_rdata, bus_ack,
    output ex_ready,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output wb_valid, wb_we, wb_rd, wb_data, misaligned, bus_err
  );

  modport slave (
    output ex_valid, alu_out, rs2_data, mem_read, mem_write, funct3, rd, reg_write,
    output bus_rdata, bus_ack,
    input  ex_ready,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  wb_valid, wb_we, wb_rd, wb_data, misaligned, bus_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: ALU pass-through, byte-lane store/load steering over a req/ack bus.
// Define MEM_TIMEOUT_EN to abort bus transfers left unacknowledged for TIMEOUT cycles.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.master mif,
  output logic [0:0]       dbg_state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUS  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        ex_ready_q, ex_ready_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_err_q, bus_err_d;

  // Context of the access in flight, needed when the ack arrives.
  logic        is_load_q, is_load_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_write_q, reg_write_d;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  logic        accept;
  logic        is_mem;
  logic        f3_bad;
  logic        addr_bad;
  logic        acc_illegal;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] rdata_shifted;
  logic [31:0] load_val;

  assign accept = mif.ex_valid && ex_ready_q;
  assign is_mem = mif.mem_read || mif.mem_write;
  assign f3_bad = (mif.funct3 == 3'd3) || (mif.funct3 == 3'd6) || (mif.funct3 == 3'd7);
  assign addr_bad = ((mif.funct3[1:0] == 2'd1) && mif.alu_out[0]) ||
                    ((mif.funct3[1:0] == 2'd2) && (mif.alu_out[1:0] != 2'b00));
  assign acc_illegal = (mif.mem_read && mif.mem_write) || f3_bad || addr_bad;

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = mif.rs2_data;
    case (mif.funct3[1:0])
      2'd0: begin
        be_calc    = 4'b0001 << mif.alu_out[1:0];
        wdata_calc = {4{mif.rs2_data[7:0]}};
      end
      2'd1: begin
        be_calc    = 4'b0011 << mif.alu_out[1:0];
        wdata_calc = {2{mif.rs2_data[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = mif.rs2_data;
      end
    endcase
  end

  assign rdata_shifted = mif.bus_rdata >> {addr_lo_q, 3'b000};

  always_comb begin
    load_val = rdata_shifted;
    case (f3_q)
      3'd0:    load_val = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'd1:    load_val = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'd4:    load_val = {24'd0, rdata_shifted[7:0]};
      3'd5:    load_val = {16'd0, rdata_shifted[15:0]};
      default: load_val = rdata_shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_be_d     = bus_be_q;
    wb_valid_d   = 1'b0;
    wb_we_d      = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    misaligned_d = 1'b0;
    bus_err_d    = 1'b0;
    is_load_d    = is_load_q;
    f3_d         = f3_q;
    addr_lo_d    = addr_lo_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
`ifdef MEM_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_we_d    = mif.reg_write;
            wb_rd_d    = mif.rd;
            wb_data_d  = mif.alu_out;
          end else if (acc_illegal) begin
            wb_valid_d   = 1'b1;
            wb_rd_d      = mif.rd;
            misaligned_d = 1'b1;
          end else begin
            state_d     = S_BUS;
            bus_req_d   = 1'b1;
            bus_we_d    = mif.mem_write;
            bus_addr_d  = {mif.alu_out[31:2], 2'b00};
            bus_be_d    = be_calc;
            bus_wdata_d = wdata_calc;
            is_load_d   = mif.mem_read;
            f3_d        = mif.funct3;
            addr_lo_d   = mif.alu_out[1:0];
            rd_d        = mif.rd;
            reg_write_d = mif.reg_write;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_d   = '0;
`endif
          end
        end
      end
      S_BUS: begin
        // An ack in the timeout cycle still completes the transfer normally.
        if (mif.bus_ack) begin
          state_d    = S_IDLE;
          bus_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_we_d    = is_load_q && reg_write_q;
          wb_rd_d    = rd_q;
          if (is_load_q) wb_data_d = load_val;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_cnt_q == CW'(TIMEOUT - 1)) begin
          state_d    = S_IDLE;
          bus_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          bus_err_d  = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    ex_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ex_ready_q   <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_be_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      is_load_q    <= 1'b0;
      f3_q         <= '0;
      addr_lo_q    <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ex_ready_q   <= ex_ready_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_be_q     <= bus_be_d;
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
      is_load_q    <= is_load_d;
      f3_q         <= f3_d;
      addr_lo_q    <= addr_lo_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  assign mif.ex_ready   = ex_ready_q;
  assign mif.bus_req    = bus_req_q;
  assign mif.bus_we     = bus_we_q;
  assign mif.bus_addr   = bus_addr_q;
  assign mif.bus_wdata  = bus_wdata_q;
  assign mif.bus_be     = bus_be_q;
  assign mif.wb_valid   = wb_valid_q;
  assign mif.wb_we      = wb_we_q;
  assign mif.wb_rd      = wb_rd_q;
  assign mif.wb_data    = wb_data_q;
  assign mif.misaligned = misaligned_q;
  assign mif.bus_err    = bus_err_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory stage placed directly after the execute ALU. Accepts one executed instruction per handshake. ALU results pass straight to writeback; load/store ops drive a single-master data bus with a req/ack handshake.
- Stores: byte-lane steering.
- Loads: extraction with sign/zero extension.
Output is a registered writeback record for the register file.

Parameters:
TIMEOUT, 16, max cycles bus_req may stay unacknowledged (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
ex_valid  in  1  execute-stage result valid
ex_ready  out  1  unit can accept (high only in IDLE)
alu_out  in  32  ALU result / effective address
rs2_data  in  32  store data
mem_read  in  1  load op
mem_write  in  1  store op
funct3  in  3  access size/sign (0 B, 1 H, 2 W, 4 BU, 5 HU)
rd  in  5  destination register
reg_write  in  1  instruction writes rd
bus_req  out  1  bus request
bus_we  out  1  1=write
bus_addr  out  32  word-aligned address
bus_wdata  out  32  lane-replicated store data
bus_be  out  4  byte enables
bus_rdata  in  32  read data, valid with bus_ack
bus_ack  in  1  transfer complete
wb_valid  out  1  one-cycle writeback pulse
wb_we  out  1  register-file write enable
wb_rd  out  5  writeback register
wb_data  out  32  writeback value
misaligned  out  1  one-cycle pulse: misaligned or illegal access
bus_err  out  1  one-cycle timeout pulse (0 without MEM_TIMEOUT_EN)

Behaviour:
- Single clock clk. Reset is synchronous, active-low on rst_n.
- While rst_n=0, all outputs are 0. ex_ready=1 from the first cycle after release. State resets to IDLE.
- FSM states: IDLE, BUS.
- Accept: ex_valid & ex_ready in IDLE. Capture all inputs.
- Non-memory op (mem_read=mem_write=0):
  - Stay IDLE.
  - Next cycle: wb_valid=1, wb_we=reg_write, wb_rd=rd, wb_data=alu_out.
  - Sustains 1 op/cycle.
- Memory op, legal and aligned:
  - Go to BUS. bus_req=1 from the next cycle.
  - bus_addr = {alu_out[31:2],2'b00}.
  - bus_we, bus_addr, bus_wdata, bus_be are held stable until the bus_ack cycle.
- Byte enables: B → 1<<addr[1:0]; H → 4'b0011 << addr[1:0]; W → 4'b1111.
- Store data: SB replicates rs2[7:0] x4. SH replicates rs2[15:0] x2. SW uses rs2 unchanged.
- In BUS, ex_ready=0. On bus_ack:
  - bus_req drops the next cycle.
  - FSM returns to IDLE; ex_ready=1 the next cycle.
  - wb_valid pulses the next cycle.
- Load result: selected lane. LB/LH sign-extend; LBU/LHU zero-extend. wb_we=reg_write.
- Store result: wb_we=0.
- Alignment legality: H needs addr[0]=0; W needs addr[1:0]=0.
- Error cases, each giving next cycle misaligned=1, wb_valid=1, wb_we=0, no bus_req, stay IDLE:
  - misaligned access;
  - funct3 in {3,6,7} on a memory op;
  - mem_read & mem_write both set.
- bus_ack in IDLE is ignored.
- Reset asserted while in BUS: bus_req=0 the next cycle. A late ack is ignored and no writeback occurs.
- wb_valid, misaligned and bus_err are single-cycle pulses. wb_rd and wb_data hold their last values otherwise.

Optional Feature:
MEM_TIMEOUT_EN
- With the macro: a counter clears on entry to BUS and increments each BUS cycle without bus_ack.
  - After TIMEOUT unacked cycles: drop bus_req, return to IDLE.
  - Next cycle: bus_err=1, wb_valid=1, wb_we=0.
  - An ack arriving in the same cycle as the timeout wins: normal completion.
- Without the macro: BUS waits indefinitely; bus_err is constant 0 and no counter exists.

Test Plan:
- ALU pass-through: accept alu_out=0x00001234, rd=5, reg_write=1 → next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x00001234. Back-to-back ops give consecutive wb pulses.
- LB at 0x1003, rdata=0x80FFFFFF, ack after 1 cycle → bus_addr=0x1000, be=4'b1000, wb_data=0xFFFFFF80. Same access with LBU → 0x00000080.
- SH at 0x2002, rs2=0xABCD1234, ack after 3 cycles → bus_req held 3 cycles, we=1, be=4'b1100, wdata=0x12341234; wb_valid=1, wb_we=0.
- LW at 0x1001 → no bus_req, misaligned=1 and wb_valid=1 with wb_we=0 one cycle after accept, ex_ready stays 1.
- Reset mid-BUS on an LW at 0x3000: assert rst_n=0 before ack, then ack one cycle after release → bus_req=0, no wb_valid, ex_ready=1.
- MEM_TIMEOUT_EN, TIMEOUT=4, never ack → bus_req high exactly 4 cycles, then bus_err=1, wb_valid=1, wb_we=0, FSM back in IDLE.
